// File: rtl/lfsr_gen_sel.sv
// lfsr_gen_sel: Fibonacci LFSR with load, zero-seed recovery and strided output scrambling.
// Optional full-period WRAP pulse is built only when LFSR_GEN_SEL_PERIOD_EN is defined.
module lfsr_gen_sel #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] TAPS     = 16'h8016,
    parameter logic [WIDTH-1:0] SEED_RST = 16'h0001,
    parameter int               OUTW     = 15,
    parameter int               STRIDE   = 7
) (
    input  logic             TRIG,
    input  logic             RESET,
    input  logic             EN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] SEED,
    output logic [WIDTH-1:0] STATE,
    output logic [OUTW-1:0]  OUT,
    output logic             LOCKUP,
    output logic             WRAP
);
    logic [WIDTH-1:0] d;
    logic             fb;
    logic             d_zero;
    logic             lockup;

    if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
        $error("lfsr_gen_sel: WIDTH must be within 4..32");
    end
    if (OUTW < 1 || OUTW > WIDTH) begin : g_bad_outw
        $error("lfsr_gen_sel: OUTW must be within 1..WIDTH");
    end
    if (SEED_RST == '0) begin : g_bad_seed
        $error("lfsr_gen_sel: SEED_RST must be nonzero");
    end

    // feedback bit and all-zero detection from the current register
    always_comb begin
        fb     = ^(d & TAPS);
        d_zero = (d == '0);
    end

    // register update: reset, then load, then step, then hold; zero seeds recover to SEED_RST
    always_ff @(posedge TRIG) begin
        if (!RESET) begin
            d      <= SEED_RST;
            lockup <= 1'b0;
        end else if (LOAD) begin
            d      <= (SEED == '0) ? SEED_RST : SEED;
            lockup <= (SEED == '0);
        end else if (EN) begin
            d      <= d_zero ? SEED_RST : {d[WIDTH-2:0], fb};
            lockup <= d_zero;
        end else begin
            lockup <= 1'b0;
        end
    end

    for (genvar i = 0; i < OUTW; i++) begin : g_out
        localparam int k = (i * STRIDE) % WIDTH;
        assign OUT[i] = d[k];
    end

    assign STATE  = d;
    assign LOCKUP = lockup;

`ifdef LFSR_GEN_SEL_PERIOD_EN
    localparam logic [WIDTH-1:0] LAST = {{(WIDTH-1){1'b1}}, 1'b0};
    logic [WIDTH-1:0] cnt;
    logic             wrap;

    // count accepted steps; pulse wrap on the step that completes the 2^WIDTH-1 period
    always_ff @(posedge TRIG) begin
        if (!RESET || LOAD) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else if (EN) begin
            cnt  <= (d_zero || cnt == LAST) ? '0 : cnt + 1'b1;
            wrap <= !d_zero && cnt == LAST;
        end else begin
            wrap <= 1'b0;
        end
    end

    assign WRAP = wrap;
`else
    assign WRAP = 1'b0;
`endif
endmodule

// File: tb/tb_lfsr_gen_sel.sv
// tb_lfsr_gen_sel: directed checks of a 4-bit and a default 16-bit lfsr_gen_sel.
module tb_lfsr_gen_sel;
    logic        trig = 1'b0;
    logic        reset;
    logic        s_en, s_load;
    logic [3:0]  s_seed, s_state, s_out;
    logic        s_lockup, s_wrap;
    logic        b_en, b_load;
    logic [15:0] b_seed, b_state;
    logic [14:0] b_out;
    logic        b_lockup, b_wrap;
    int          tests = 0;
    int          fails = 0;

    always #5 trig = ~trig;

    lfsr_gen_sel #(.WIDTH(4), .TAPS(4'hC), .SEED_RST(4'h1), .OUTW(4), .STRIDE(3)) u_small (
        .TRIG(trig), .RESET(reset), .EN(s_en), .LOAD(s_load), .SEED(s_seed),
        .STATE(s_state), .OUT(s_out), .LOCKUP(s_lockup), .WRAP(s_wrap)
    );

    lfsr_gen_sel u_big (
        .TRIG(trig), .RESET(reset), .EN(b_en), .LOAD(b_load), .SEED(b_seed),
        .STATE(b_state), .OUT(b_out), .LOCKUP(b_lockup), .WRAP(b_wrap)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge trig);
        #1;
    endtask

    logic [3:0] seq [15] = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                             4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
    logic       wrap_exp;

    initial begin
        reset = 1'b0; s_en = 1'b1; s_load = 1'b0; s_seed = 4'h0;
        b_en = 1'b1; b_load = 1'b0; b_seed = 16'h0;
        tick();
        chk("rst_s_state", s_state, 4'h1);
        chk("rst_s_lockup", s_lockup, 0);
        chk("rst_s_wrap", s_wrap, 0);
        chk("rst_b_state", b_state, 16'h0001);
        chk("rst_b_out", b_out, 15'h0001);
        chk("rst_b_lockup", b_lockup, 0);
        reset = 1'b1; b_en = 1'b0;
        for (int n = 0; n < 15; n++) begin
            tick();
`ifdef LFSR_GEN_SEL_PERIOD_EN
            wrap_exp = (n == 14);
`else
            wrap_exp = 1'b0;
`endif
            chk($sformatf("step%0d_state", n + 1), s_state, seq[n]);
            chk($sformatf("step%0d_wrap", n + 1), s_wrap, wrap_exp);
        end
        s_en = 1'b0;
        tick();
        chk("hold_state", s_state, 4'h1);
        chk("hold_wrap", s_wrap, 0);
        s_en = 1'b1;
        repeat (5) tick();
        chk("five_steps", s_state, 4'h6);
        reset = 1'b0;
        tick();
        chk("midrst_state", s_state, 4'h1);
        chk("midrst_wrap", s_wrap, 0);
        chk("midrst_lockup", s_lockup, 0);
        reset = 1'b1;
        tick();
        chk("after_rst_step", s_state, 4'h2);
        s_en = 1'b0; s_load = 1'b1; s_seed = 4'h0;
        tick();
        chk("zseed_state", s_state, 4'h1);
        chk("zseed_lockup", s_lockup, 1);
        s_load = 1'b0;
        tick();
        chk("zseed_lockup_end", s_lockup, 0);
        chk("zseed_hold", s_state, 4'h1);
        s_load = 1'b1; s_en = 1'b1; s_seed = 4'h9;
        tick();
        chk("s_load_pri", s_state, 4'h9);
        chk("s_load_lockup", s_lockup, 0);
        s_load = 1'b0; s_en = 1'b0;
        b_load = 1'b1; b_en = 1'b1; b_seed = 16'hACE1;
        tick();
        chk("b_load_pri", b_state, 16'hACE1);
        b_load = 1'b0;
        tick();
        chk("b_step", b_state, 16'h59C3);
        b_en = 1'b0; b_load = 1'b1; b_seed = 16'h0080;
        tick();
        chk("b_out_0080", b_out, 15'h0002);
        b_seed = 16'h8000;
        tick();
        chk("b_out_8000", b_out, 15'h0200);
        chk("b_wrap_idle", b_wrap, 0);
        b_load = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
